// File: rtl/aca_csu_vl.sv
// aca_csu_vl -- variable-latency ACA-CSU approximate adder.
//
// Each operation first produces a carry-speculated sum. Every block guesses
// its carry-in from the block below it, or from the MSB generate of the block
// two below when the block below fully propagates. The exact sum is computed
// alongside so the result can be flagged. In exact mode, a flagged result
// spends one extra cycle in FIX, where it is replaced by the exact sum of the
// held operands.
//
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   in_valid / in_ready   operand handshake (a, b, mode)
//   a, b [WIDTH]          unsigned operands
//   mode                  0 = approximate only, 1 = correct on error
//   out_valid / out_ready result handshake
//   sum [WIDTH+1]         result, sum[WIDTH] is the carry-out
//   err                   speculative sum differed from exact a+b
//   corrected             sum came from a correction cycle
//   err_cnt [16]          saturating count of accepted ops with err=1

// One speculation block: exact BLK-bit add with a guessed carry-in. It also
// reports its own generate (carry-out with cin=0) and its group propagate.
module aca_csu_vl_blk #(
  parameter int BLK = 4
) (
  input  logic [BLK-1:0] a,
  input  logic [BLK-1:0] b,
  input  logic           cin,
  output logic [BLK-1:0] s,
  output logic           cout,
  output logic           gen,
  output logic           bp
);
  logic [BLK:0] t0, t1;

  assign t0   = {1'b0, a} + {1'b0, b};
  assign t1   = t0 + {{BLK{1'b0}}, cin};
  assign gen  = t0[BLK];
  assign bp   = &(a ^ b);
  assign s    = t1[BLK-1:0];
  assign cout = t1[BLK];
endmodule

module aca_csu_vl #(
  parameter int WIDTH = 32,
  parameter int BLK   = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH:0]   sum,
  output logic             err,
  output logic             corrected,
  output logic [15:0]      err_cnt
);
  localparam int NB = WIDTH / BLK;

  typedef enum logic [1:0] {EMPTY, FIX, HOLD} state_t;

  typedef struct packed {
    logic [WIDTH:0] sum;
    logic           err;
    logic           corrected;
  } rsp_t;

  state_t state, state_nx;
  rsp_t   rsp_q;
  logic   accept;

  logic [WIDTH-1:0] a_q, b_q;

  // ---------------- speculative adder ----------------
  logic [NB-1:0][BLK-1:0] ab, bb, sb;
  logic [NB-1:0]          cin, cout, gen, bp;
  logic [WIDTH-1:0]       g;
  logic [WIDTH:0]         spec_sum, exact_sum, fix_sum;
  logic                   spec_err;

  assign ab = a;
  assign bb = b;
  assign g  = a & b;

  for (genvar k = 0; k < NB; k++) begin : g_blk
    if (k == 0) begin : g_c0
      assign cin[k] = 1'b0;
    end else if (k == 1) begin : g_c1
      assign cin[k] = gen[0];
    end else begin : g_cn
      // When block k-1 fully propagates, its own generate is 0, so the guess
      // falls back to the MSB generate of block k-2.
      assign cin[k] = bp[k-1] ? g[k*BLK-BLK-1] : gen[k-1];
    end

    aca_csu_vl_blk #(.BLK(BLK)) u_blk (
      .a    (ab[k]),
      .b    (bb[k]),
      .cin  (cin[k]),
      .s    (sb[k]),
      .cout (cout[k]),
      .gen  (gen[k]),
      .bp   (bp[k])
    );
  end

  assign spec_sum  = {cout[NB-1], sb};
  assign exact_sum = {1'b0, a} + {1'b0, b};
  assign spec_err  = (spec_sum != exact_sum);
  assign fix_sum   = {1'b0, a_q} + {1'b0, b_q};

  // ---------------- control ----------------
  always_ff @(posedge clk) begin
    if (!rst_n) state <= EMPTY;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    out_valid = 1'b0;
    in_ready  = 1'b0;
    case (state)
      EMPTY: in_ready = rst_n;
      FIX:   state_nx = HOLD;
      HOLD: begin
        out_valid = 1'b1;
        in_ready  = rst_n & out_ready;
        if (out_ready && !in_valid) state_nx = EMPTY;
      end
      default: state_nx = EMPTY;
    endcase
    accept = in_valid & in_ready;
    // Accepting overrides the per-state choice. This is also the
    // same-edge handoff from HOLD.
    if (accept) state_nx = (mode && spec_err) ? FIX : HOLD;
  end

  // ---------------- datapath ----------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rsp_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      err_cnt <= '0;
    end else if (accept) begin
      a_q             <= a;
      b_q             <= b;
      rsp_q.sum       <= spec_sum;
      rsp_q.err       <= spec_err;
      rsp_q.corrected <= 1'b0;
      if (spec_err && err_cnt != 16'hFFFF) err_cnt <= err_cnt + 16'd1;
    end else if (state == FIX) begin
      rsp_q.sum       <= fix_sum;
      rsp_q.corrected <= 1'b1;
    end
  end

  assign sum       = rsp_q.sum;
  assign err       = rsp_q.err;
  assign corrected = rsp_q.corrected;
endmodule

// File: doc/aca_csu_vl.md
# aca_csu_vl

Parametrised, variable-latency ACA-CSU approximate adder with valid/ready handshake, a runtime exact/approximate mode, speculation-error detection and one-cycle correction. It is the pipelined successor of the fixed 16-bit/4-bit-block combinational ACA-CSU adders, for datapaths that must trade latency for exactness per operation. It also keeps a saturating error counter for accuracy profiling.

## Interface
- WIDTH, 32: operand width. Must be a multiple of BLK and at least 2*BLK.
- BLK, 4: carry-speculation block size in bits. Number of blocks is NB = WIDTH/BLK.
- clk  in  1: clock; all state changes on the rising edge.
- rst_n  in  1: reset, synchronous, active-low.
- in_valid  in  1: operands valid.
- in_ready  out  1: block can accept operands this cycle.
- a, b  in  WIDTH: operands, unsigned.
- mode  in  1: 0 = approximate only; 1 = exact (correct on error). Sampled with the operands.
- out_valid  out  1: result valid.
- out_ready  in  1: consumer accepts the result.
- sum  out  WIDTH+1: result; sum[WIDTH] is the carry-out.
- err  out  1: the speculative result differed from the exact a+b.
- corrected  out  1: sum is the exact value produced by a correction cycle.
- err_cnt  out  16: count of accepted operations with err=1; saturates at 0xFFFF.

## Operation
- Bit signals are p=a^b and g=a&b. Block k covers bits [k*BLK+BLK-1 : k*BLK].
- gen_k is the carry-out of block k assuming carry-in 0. bp_k is the AND of all p bits in block k.
- Speculative block carry-ins:
  - cin_0 = 0.
  - cin_1 = gen_0.
  - For k≥2: cin_k = bp_{k-1} ? g[k*BLK-BLK-1] : gen_{k-1}. The index k*BLK-BLK-1 is the MSB of block k-2.
- Each block is an exact BLK-bit add of p/g with cin_k. Spec sum[WIDTH] is the carry-out of block NB-1.
- err = (spec sum != exact a+b), with both taken at WIDTH+1 bits.
- FSM states are EMPTY, FIX and HOLD.
- Operand accept happens when in_valid && in_ready. On accept:
  - Register a, b and mode.
  - Register the spec sum into sum, register err, and set corrected=0.
  - If err=1, err_cnt increments (saturating).
  - If mode=1 && err=1, go to FIX. Otherwise go to HOLD.
- EMPTY: out_valid=0, in_ready=1. Accept as above; with no accept, stay.
- FIX:
  - out_valid=0, in_ready=0.
  - Next edge: sum ← exact a+b of the held operands, corrected ← 1, err stays 1, go to HOLD.
- HOLD:
  - out_valid=1, in_ready=out_ready (combinational).
  - out_ready && in_valid: accept new operands, same-edge handoff.
  - out_ready && !in_valid: go to EMPTY.
  - !out_ready: stay. sum, err and corrected are held stable.
- In mode 0, err is reported but sum stays approximate and corrected=0.

## Timing
- Reset (rst_n=0 at an edge) forces:
  - state EMPTY
  - out_valid=0, sum=0, err=0, corrected=0, err_cnt=0
- in_ready is 0 while rst_n=0.
- Reset during FIX or HOLD discards the pending result. No output appears afterwards.
- Latency from accept edge to out_valid:
  - 1 cycle for mode 0, or mode 1 without error.
  - 2 cycles for mode 1 with error.
- Throughput: 1 op/cycle with out_ready held high and no corrections. Each correction costs one bubble.
- Once out_valid=1, outputs are stable until the handshake completes.
- A result is never dropped or duplicated.
- err_cnt updates on the accept edge and is never affected by backpressure.

## Test plan
All scenarios use WIDTH=16, BLK=4.
- a=0x1234, b=0x4321, mode=1 → one cycle later: out_valid=1, sum=0x05555, err=0, corrected=0.
- a=0x00FF, b=0x0001:
  - mode=0 → 1 cycle: sum=0x00000, err=1, corrected=0.
  - mode=1 → 2 cycles: sum=0x00100, err=1, corrected=1.
  - err_cnt=2 after both.
- a=0x00F8, b=0x0008, mode=1 → 1 cycle: sum=0x00100, err=0. The g-rescue path is exercised.
- a=0xFFFF, b=0x0001:
  - mode=0 → sum=0x0FF00, err=1.
  - mode=1 → sum=0x10000, corrected=1. The carry-out is exercised.
- Backpressure: hold out_ready=0 for 3 cycles with in_valid=1 → in_ready=0 and sum stable. Then release → back-to-back results in order, none lost. In random regression, every exact/corrected output matches a+b, and every mode-0 output matches the spec model.
- Deassert rst_n during FIX → next cycle out_valid=0, err_cnt=0, state EMPTY. After 0xFFFF error ops plus one more, err_cnt stays 0xFFFF.
